// File: rtl/sram_wb_arb_if.sv
// Signal bundle around the SRAM data-port arbiter.
//   slave  : the arbiter's view (core and Wishbone requests in, SRAM responses in,
//            grants/acks/SRAM commands out)
//   master : the surrounding environment (core, management SoC, SRAM port)
// Groups: core_*  core data port (req/gnt/rvalid)
//         wbs_*   Wishbone classic slave
//         sram_*  downstream SRAM data port
//         illegal_o  pulse on out-of-window Wishbone access
interface sram_wb_arb_if;
  logic        core_req_i;
  logic        core_gnt_o;
  logic [31:0] core_addr_i;
  logic        core_we_i;
  logic [3:0]  core_be_i;
  logic [31:0] core_wdata_i;
  logic        core_rvalid_o;
  logic [31:0] core_rdata_o;

  logic        wbs_cyc_i;
  logic        wbs_stb_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;

  logic        sram_req_o;
  logic        sram_gnt_i;
  logic        sram_we_o;
  logic [31:0] sram_addr_o;
  logic [3:0]  sram_be_o;
  logic [31:0] sram_wdata_o;
  logic        sram_rvalid_i;
  logic [31:0] sram_rdata_i;

  logic        illegal_o;

  modport slave (
    input  core_req_i, core_addr_i, core_we_i, core_be_i, core_wdata_i,
    output core_gnt_o, core_rvalid_o, core_rdata_o,
    input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_ack_o, wbs_dat_o,
    output sram_req_o, sram_we_o, sram_addr_o, sram_be_o, sram_wdata_o,
    input  sram_gnt_i, sram_rvalid_i, sram_rdata_i,
    output illegal_o
  );

  modport master (
    output core_req_i, core_addr_i, core_we_i, core_be_i, core_wdata_i,
    input  core_gnt_o, core_rvalid_o, core_rdata_o,
    output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_ack_o, wbs_dat_o,
    input  sram_req_o, sram_we_o, sram_addr_o, sram_be_o, sram_wdata_o,
    output sram_gnt_i, sram_rvalid_i, sram_rdata_i,
    input  illegal_o
  );
endinterface

// File: rtl/sram_wb_arb.sv
// Arbitrates the SRAM data port between the core data port and a Wishbone
// classic slave (management-SoC program load / debug path).
// Ports:
//   clk_i  clock
//   rst_i  synchronous active-high reset
//   bus    sram_wb_arb_if.slave: core_*, wbs_*, sram_*, illegal_o
// The core normally owns the port; a pending Wishbone request wins whenever the
// core is idle, or after MAX_WAIT cycles lost to the core.
//
// state | meaning
// IDLE  | no Wishbone access in flight
// REQ   | Wishbone access latched, waiting to win the SRAM port
// WAIT  | Wishbone access issued, waiting for SRAM rvalid
// ACK   | ack visible on the bus (suppressed if cyc dropped)
// ERR   | out-of-window access, error-style ack, no SRAM access
module sram_wb_arb #(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter logic [31:0] ADDR_MASK = 32'hFFFF_0000,
  parameter int unsigned MAX_WAIT  = 4
) (
  input logic          clk_i,
  input logic          rst_i,
  sram_wb_arb_if.slave bus
);
  localparam int unsigned CW = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_WAIT);

  typedef enum logic [2:0] {IDLE, REQ, WAIT, ACK, ERR} state_t;
  typedef enum logic [1:0] {OWN_NONE, OWN_CORE, OWN_WB} owner_t;

  state_t        state, state_nxt;
  owner_t        owner, owner_nxt;
  logic [CW-1:0] starve_cnt, starve_nxt;
  logic [31:0]   adr_lat, dat_lat;
  logic [3:0]    sel_lat;
  logic          we_lat;
  logic          ack, ack_nxt;
  logic          illegal, illegal_nxt;
  logic [31:0]   rdat, rdat_nxt;
  logic          wb_access, hit, wb_win, wb_rsp;

  assign wb_access = bus.wbs_cyc_i & bus.wbs_stb_i;
  assign hit       = (bus.wbs_adr_i & ADDR_MASK) == BASE_ADDR;
  assign wb_win    = (state == REQ) & (~bus.core_req_i | (starve_cnt == MAX_CNT));
  // Only a response to our own issued access completes the Wishbone cycle.
  assign wb_rsp    = (state == WAIT) & bus.sram_rvalid_i & (owner == OWN_WB);

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (wb_access) state_nxt = hit ? REQ : ERR;
      REQ:     if (wb_win & bus.sram_gnt_i) state_nxt = WAIT;
      WAIT:    if (wb_rsp) state_nxt = ACK;
      ACK:     state_nxt = IDLE;
      ERR:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Ack/illegal/read data are registered, so their next values are decoded
  // one cycle ahead of the ACK/ERR states they appear in.
  always_comb begin
    ack_nxt     = 1'b0;
    illegal_nxt = 1'b0;
    rdat_nxt    = rdat;
    case (state)
      IDLE: if (wb_access & ~hit) begin
        ack_nxt     = 1'b1;
        illegal_nxt = 1'b1;
        rdat_nxt    = '0;
      end
      WAIT: if (wb_rsp) begin
        ack_nxt = bus.wbs_cyc_i;
        if (!we_lat) rdat_nxt = bus.sram_rdata_i;
      end
      default: ;
    endcase

    if ((state == REQ) && !wb_win && (starve_cnt != MAX_CNT)) starve_nxt = starve_cnt + 1'b1;
    else                                                       starve_nxt = '0;

    if (wb_win & bus.sram_gnt_i)              owner_nxt = OWN_WB;
    else if (bus.core_req_i & bus.sram_gnt_i) owner_nxt = OWN_CORE;
    else                                      owner_nxt = OWN_NONE;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      starve_cnt <= '0;
      owner      <= OWN_NONE;
      ack        <= 1'b0;
      illegal    <= 1'b0;
      rdat       <= '0;
      adr_lat    <= '0;
      dat_lat    <= '0;
      sel_lat    <= '0;
      we_lat     <= 1'b0;
    end else begin
      starve_cnt <= starve_nxt;
      owner      <= owner_nxt;
      ack        <= ack_nxt;
      illegal    <= illegal_nxt;
      rdat       <= rdat_nxt;
      if ((state == IDLE) && wb_access && hit) begin
        adr_lat <= bus.wbs_adr_i & ~ADDR_MASK;
        dat_lat <= bus.wbs_dat_i;
        sel_lat <= bus.wbs_sel_i;
        we_lat  <= bus.wbs_we_i;
      end
    end
  end

  assign bus.core_gnt_o    = bus.core_req_i & ~wb_win & bus.sram_gnt_i;
  assign bus.sram_req_o    = wb_win | bus.core_req_i;
  assign bus.sram_we_o     = wb_win ? we_lat  : bus.core_we_i;
  assign bus.sram_addr_o   = wb_win ? adr_lat : bus.core_addr_i;
  assign bus.sram_be_o     = wb_win ? sel_lat : bus.core_be_i;
  assign bus.sram_wdata_o  = wb_win ? dat_lat : bus.core_wdata_i;

  assign bus.core_rvalid_o = bus.sram_rvalid_i & (owner == OWN_CORE);
  assign bus.core_rdata_o  = bus.core_rvalid_o ? bus.sram_rdata_i : 32'h0;

  assign bus.wbs_ack_o     = ack;
  assign bus.wbs_dat_o     = rdat;
  assign bus.illegal_o     = illegal;
endmodule

// File: tb/tb_sram_wb_arb.sv
// Bench for sram_wb_arb: behavioural SRAM port model plus a cycle-level
// reference of the arbitration rules, directed cases then randomized traffic.
module tb_sram_wb_arb;
  localparam logic [31:0] BASE = 32'h3000_0000;
  localparam logic [31:0] MASK = 32'hFFFF_0000;
  localparam int          MAXW = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sram_wb_arb_if bus ();

  sram_wb_arb #(.BASE_ADDR(BASE), .ADDR_MASK(MASK), .MAX_WAIT(MAXW)) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  // SRAM port: gnt = req, response exactly one cycle after every request.
  logic [31:0] sram_mem [0:63] = '{default: 32'h0};
  logic        inject;
  assign bus.sram_gnt_i = bus.sram_req_o;
  always @(posedge clk) begin
    bus.sram_rvalid_i <= bus.sram_req_o | inject;
    if (inject)                                    bus.sram_rdata_i <= 32'hDEAD_BEEF;
    else if (bus.sram_req_o && !bus.sram_we_o)     bus.sram_rdata_i <= sram_mem[bus.sram_addr_o[7:2]];
    else                                           bus.sram_rdata_i <= 32'h0;
    if (bus.sram_req_o && bus.sram_we_o)
      for (int b = 0; b < 4; b++)
        if (bus.sram_be_o[b]) sram_mem[bus.sram_addr_o[7:2]][8*b +: 8] <= bus.sram_wdata_o[8*b +: 8];
  end

  // Reference state
  logic [31:0] ref_mem [0:63] = '{default: 32'h0};
  logic        exp_rv;
  logic [31:0] exp_rd;
  logic [31:0] exp_wbdat;
  int          tests = 0;
  int          fails = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic mem_wr(input logic [5:0] idx, input logic [3:0] be, input logic [31:0] d);
    for (int b = 0; b < 4; b++) if (be[b]) ref_mem[idx][8*b +: 8] = d[8*b +: 8];
  endtask

  // One Wishbone access starting in cycle 0 with the core requesting per cpat.
  // The WB side wins on the first REQ cycle where the core is idle, or after
  // MAXW cycles lost to the core; ack follows the win by two cycles.
  task automatic wb_txn(input logic we, input logic [31:0] adr, input logic [3:0] sel,
                        input logic [31:0] dat, input logic [15:0] cpat, input bit drop);
    bit          hit, win, gnt_e, act, creq, cwe, ack_e;
    int          w, ack_c, drop_at;
    logic [31:0] ca, cd;
    logic [3:0]  cbe;
    hit = ((adr & MASK) == BASE);
    if (hit) begin
      w = 1;
      while (w < 1 + MAXW && cpat[w]) w++;
      ack_c = w + 2;
    end else begin
      w = -1;
      ack_c = 1;
    end
    drop_at = (hit && drop) ? w + 1 : 1000;
    for (int c = 0; c <= ack_c + 1; c++) begin
      act  = (c <= ack_c) && (c < drop_at);
      creq = (c <= ack_c) ? cpat[c] : 1'b0;
      ca   = {24'h0, 6'($urandom_range(0, 63)), 2'b00};
      cwe  = 1'($urandom_range(0, 1));
      cbe  = 4'($urandom);
      cd   = $urandom;
      bus.wbs_cyc_i = act;  bus.wbs_stb_i = act;  bus.wbs_we_i = we;
      bus.wbs_sel_i = sel;  bus.wbs_adr_i = adr;  bus.wbs_dat_i = dat;
      bus.core_req_i = creq; bus.core_addr_i = ca; bus.core_we_i = cwe;
      bus.core_be_i = cbe;   bus.core_wdata_i = cd;
      @(negedge clk);
      win   = hit && (c == w);
      gnt_e = creq && !win;
      ack_e = (c == ack_c) && !(hit && drop);
      check("core_gnt",    bus.core_gnt_o,    gnt_e);
      check("sram_req",    bus.sram_req_o,    creq || win);
      check("core_rvalid", bus.core_rvalid_o, exp_rv);
      check("core_rdata",  bus.core_rdata_o,  exp_rv ? exp_rd : 32'h0);
      check("wbs_ack",     bus.wbs_ack_o,     ack_e);
      check("illegal",     bus.illegal_o,     !hit && (c == 1));
      if (ack_e) check("wbs_dat", bus.wbs_dat_o, exp_wbdat);
      if (!hit && c == 0) exp_wbdat = 32'h0;
      if (win) begin
        if (we) mem_wr(adr[7:2], sel, dat);
        else    exp_wbdat = ref_mem[adr[7:2]];
      end
      exp_rv = gnt_e;
      exp_rd = (gnt_e && !cwe) ? ref_mem[ca[7:2]] : 32'h0;
      if (gnt_e && cwe) mem_wr(ca[7:2], cbe, cd);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    logic [31:0] adr;
    logic [15:0] cpat;
    rst = 1'b1; inject = 1'b0;
    bus.core_req_i = 0; bus.core_addr_i = 0; bus.core_we_i = 0; bus.core_be_i = 0; bus.core_wdata_i = 0;
    bus.wbs_cyc_i = 0; bus.wbs_stb_i = 0; bus.wbs_we_i = 0; bus.wbs_sel_i = 0;
    bus.wbs_adr_i = 0; bus.wbs_dat_i = 0;
    exp_rv = 1'b0; exp_rd = 32'h0; exp_wbdat = 32'h0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_ack",     bus.wbs_ack_o,     1'b0);
    check("rst_dat",     bus.wbs_dat_o,     32'h0);
    check("rst_illegal", bus.illegal_o,     1'b0);
    check("rst_rvalid",  bus.core_rvalid_o, 1'b0);
    check("rst_rdata",   bus.core_rdata_o,  32'h0);
    @(posedge clk); #1;

    // write then read back, full and partial byte selects
    wb_txn(1'b1, 32'h3000_0010, 4'hF, 32'h1234_5678, 16'h0, 1'b0);
    wb_txn(1'b0, 32'h3000_0010, 4'hF, 32'h0, 16'h0, 1'b0);
    check("t1_dat", bus.wbs_dat_o, 32'h1234_5678);
    wb_txn(1'b1, 32'h3000_0010, 4'h2, 32'h0000_AB00, 16'h0, 1'b0);
    wb_txn(1'b0, 32'h3000_0010, 4'hF, 32'h0, 16'h0, 1'b0);
    check("t2_dat", bus.wbs_dat_o, 32'h1234_AB78);

    // core holds req: WB forced to win after MAXW lost cycles
    wb_txn(1'b0, 32'h3000_0010, 4'hF, 32'h0, 16'hFFFF, 1'b0);
    check("t3_dat", bus.wbs_dat_o, 32'h1234_AB78);

    // out-of-window access, and just past the window top
    wb_txn(1'b0, 32'h4000_0000, 4'hF, 32'h0, 16'h0, 1'b0);
    check("t4_dat", bus.wbs_dat_o, 32'h0);
    wb_txn(1'b1, 32'h3001_0010, 4'hF, 32'h5555_5555, 16'h0, 1'b0);

    // cyc dropped during WAIT, then a normal read
    wb_txn(1'b0, 32'h3000_0010, 4'hF, 32'h0, 16'h0, 1'b1);
    wb_txn(1'b0, 32'h3000_0010, 4'hF, 32'h0, 16'h0, 1'b0);
    check("t5_dat", bus.wbs_dat_o, 32'h1234_AB78);

    // reset while the WB access sits in WAIT, with a core read in flight
    bus.wbs_cyc_i = 1; bus.wbs_stb_i = 1; bus.wbs_we_i = 0; bus.wbs_sel_i = 4'hF;
    bus.wbs_adr_i = 32'h3000_0010;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1; inject = 1'b1;
    bus.core_req_i = 1; bus.core_we_i = 0; bus.core_addr_i = 32'h10;
    @(posedge clk); #1;
    rst = 1'b0; inject = 1'b0; bus.core_req_i = 0;
    bus.wbs_cyc_i = 0; bus.wbs_stb_i = 0;
    @(negedge clk);
    check("t6_rvalid",  bus.core_rvalid_o, 1'b0);
    check("t6_rdata",   bus.core_rdata_o,  32'h0);
    check("t6_ack",     bus.wbs_ack_o,     1'b0);
    check("t6_dat",     bus.wbs_dat_o,     32'h0);
    check("t6_illegal", bus.illegal_o,     1'b0);
    check("t6_req",     bus.sram_req_o,    1'b0);
    @(posedge clk); #1;
    @(negedge clk);
    check("t6_ack2", bus.wbs_ack_o, 1'b0);
    check("t6_dat2", bus.wbs_dat_o, 32'h0);
    @(posedge clk); #1;
    exp_rv = 1'b0; exp_rd = 32'h0; exp_wbdat = 32'h0;

    // randomized mix of hits, misses, aborts and core contention
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 9))
        0:       adr = 32'h5000_0000 | {24'h0, 6'($urandom_range(0, 63)), 2'b00};
        1:       adr = 32'h3001_0000 | {24'h0, 6'($urandom_range(0, 63)), 2'b00};
        default: adr = BASE | {24'h0, 6'($urandom_range(0, 63)), 2'b00};
      endcase
      case ($urandom_range(0, 3))
        0:       cpat = 16'h0;
        1:       cpat = 16'hFFFF;
        default: cpat = 16'($urandom);
      endcase
      wb_txn(1'($urandom_range(0, 1)), adr, 4'($urandom_range(1, 15)), $urandom, cpat,
             $urandom_range(0, 7) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
